// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet winner-take-all engine: FSM state
// constants and width helpers for the Q-format datapath.
package maxnet_pkg;

    // Control FSM states
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StIter = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Default fractional bit count of the Q(W-FRAC).FRAC format
    localparam int unsigned DefaultFrac = 16;

    // Width of the activation sum: N non-negative W-bit values never overflow this
    function automatic int unsigned sum_width(input int unsigned n, input int unsigned w);
        return w + $clog2(n);
    endfunction

    // Full-precision width of eps * (S - b_i)
    function automatic int unsigned prod_width(input int unsigned w, input int unsigned sw);
        return w + sw;
    endfunction

endpackage

// File: rtl/maxnet_pe.sv
// One MaxNet processing element: next activation of channel i from its current
// activation, the sum over all channels and the inhibition weight.
// b_next = ReLU(b - ((eps * (S - b)) >>> FRAC)), computed at full width.
module maxnet_pe
    import maxnet_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = DefaultFrac,
    parameter int unsigned SW   = 34
) (
    input  logic [W-1:0]  b_i,
    input  logic [SW-1:0] sum_i,
    input  logic [W-1:0]  eps_i,
    output logic [W-1:0]  b_next_o
);

    localparam int unsigned PW = prod_width(W, SW);

    logic [SW-1:0] others;
    logic [PW-1:0] prod;
    logic [PW-1:0] inhib;
    logic [PW-1:0] b_ext;

    // Lateral inhibition then ReLU; every operand is non-negative, so a logical
    // shift gives the same floor as an arithmetic one and the compare replaces
    // the sign test on the difference.
    always_comb begin
        others   = sum_i - SW'(b_i);
        prod     = PW'(eps_i) * PW'(others);
        inhib    = prod >> FRAC;
        b_ext    = PW'(b_i);
        b_next_o = (inhib >= b_ext) ? '0 : W'(b_ext - inhib);
    end

endmodule

// File: rtl/maxnet_engine.sv
// N-channel MaxNet (winner-take-all) engine with valid/ready handshakes.
// Loads N signed Q-format scores, iterates lateral inhibition one step per
// cycle until at most one channel stays positive or MAX_ITER is reached, then
// presents the winner index and its original score.
// Optional build macro MAXNET_ITER_OUT_EN adds the out_iters port.
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 32,
    parameter int unsigned FRAC     = DefaultFrac,
    parameter int unsigned MAX_ITER = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*W-1:0]                in_data,
    input  logic [W-1:0]                  epsilon,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          found,
    output logic                          timeout,
    output logic [$clog2(N)-1:0]          win_idx,
`ifdef MAXNET_ITER_OUT_EN
    output logic [$clog2(MAX_ITER+1)-1:0] out_iters,
`endif
    output logic [W-1:0]                  max
);

    localparam int unsigned IW = $clog2(MAX_ITER + 1);
    localparam int unsigned XW = $clog2(N);
    localparam int unsigned SW = sum_width(N, W);
    localparam int unsigned CW = $clog2(N + 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] iter_q;
    logic [W-1:0]  eps_q;
    logic [W-1:0]  x_q    [N];
    logic [W-1:0]  b_q    [N];
    logic [W-1:0]  b_next [N];
    logic          found_q, timeout_q;
    logic [XW-1:0] win_q;
    logic [W-1:0]  max_q;

    logic [SW-1:0] sum;
    logic [CW-1:0] pcnt;
    logic [XW-1:0] first_pos;

    for (genvar g = 0; g < N; g++) begin : g_pe
        maxnet_pe #(
            .W    (W),
            .FRAC (FRAC),
            .SW   (SW)
        ) u_pe (
            .b_i      (b_q[g]),
            .sum_i    (sum),
            .eps_i    (eps_q),
            .b_next_o (b_next[g])
        );
    end

    // Sum, positive-channel count and lowest positive channel of registered b
    always_comb begin
        sum       = '0;
        pcnt      = '0;
        first_pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = sum + SW'(b_q[i]);
            if (!b_q[i][W-1] && (b_q[i] != '0)) begin
                pcnt      = pcnt + CW'(1);
                first_pos = XW'(i);
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StIter;
            StIter:  if ((pcnt <= CW'(1)) || (iter_q == IW'(MAX_ITER))) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            iter_q    <= '0;
            eps_q     <= '0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
            win_q     <= '0;
            max_q     <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) begin
                            x_q[i] <= in_data[i*W +: W];
                            // ReLU at load: negative scores start inactive
                            b_q[i] <= in_data[i*W + W - 1] ? '0 : in_data[i*W +: W];
                        end
                        eps_q     <= epsilon;
                        iter_q    <= '0;
                        found_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        win_q     <= '0;
                        max_q     <= '0;
                    end
                end
                StIter: begin
                    if (pcnt == CW'(1)) begin
                        found_q <= 1'b1;
                        win_q   <= first_pos;
                        max_q   <= x_q[first_pos];
                    end else if (pcnt == '0) begin
                        found_q <= 1'b0;
                    end else if (iter_q == IW'(MAX_ITER)) begin
                        timeout_q <= 1'b1;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            b_q[i] <= b_next[i];
                        end
                        iter_q <= iter_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; in_ready is held low while rst is asserted
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign found     = found_q;
    assign timeout   = timeout_q;
    assign win_idx   = win_q;
    assign max       = max_q;
`ifdef MAXNET_ITER_OUT_EN
    // Counter holds the update count from the end of ITER until the next accept
    assign out_iters = iter_q;
`endif

endmodule

// File: tb/tb_maxnet_engine.sv
// Scoreboard bench for maxnet_engine (N=4, W=32, FRAC=16, MAX_ITER=64).
// Expected results come from a real-number-style reference model on longints.
module tb_maxnet_engine;

    localparam int N        = 4;
    localparam int W        = 32;
    localparam int MAX_ITER = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_data = '0;
    logic [W-1:0]   epsilon = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           found;
    logic           timeout;
    logic [1:0]     win_idx;
    logic [W-1:0]   max;
`ifdef MAXNET_ITER_OUT_EN
    logic [6:0]     out_iters;
`endif

    maxnet_engine #(
        .N        (N),
        .W        (W),
        .FRAC     (16),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .epsilon   (epsilon),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .found     (found),
        .timeout   (timeout),
        .win_idx   (win_idx),
`ifdef MAXNET_ITER_OUT_EN
        .out_iters (out_iters),
`endif
        .max       (max)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          found;
        bit          timeout;
        int          idx;
        logic [31:0] maxv;
        int          iters;
        longint      acc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   first_valid = 1'b1;

    task automatic chk(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference model: MaxNet on plain integers, iterated until resolved
    function automatic exp_t model(input logic [N*W-1:0] d, input logic [31:0] e);
        exp_t   r;
        longint b  [N];
        longint nb [N];
        longint s;
        longint inh;
        int     p;
        int     w;
        r = '{found: 1'b0, timeout: 1'b0, idx: 0, maxv: 32'h0, iters: 0, acc: 0};
        for (int i = 0; i < N; i++) begin
            b[i] = longint'($signed(d[i*W +: W]));
            if (b[i] < 0) b[i] = 0;
        end
        for (int it = 0; it <= MAX_ITER; it++) begin
            p = 0;
            w = 0;
            s = 0;
            for (int i = N - 1; i >= 0; i--) begin
                s += b[i];
                if (b[i] > 0) begin
                    p++;
                    w = i;
                end
            end
            r.iters = it;
            if (p == 1) begin
                r.found = 1'b1;
                r.idx   = w;
                r.maxv  = d[w*W +: W];
                return r;
            end
            if (p == 0) return r;
            if (it == MAX_ITER) begin
                r.timeout = 1'b1;
                return r;
            end
            for (int i = 0; i < N; i++) begin
                inh   = (longint'(e) * (s - b[i])) >>> 16;
                nb[i] = (b[i] - inh < 0) ? 0 : b[i] - inh;
            end
            for (int i = 0; i < N; i++) b[i] = nb[i];
        end
        return r;
    endfunction

    // Monitor: compares every cycle the DUT presents a result, pops on handshake
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("spurious_out_valid");
            end else begin
                chk("found", found, exp_q[0].found);
                chk("timeout", timeout, exp_q[0].timeout);
                chk("win_idx", win_idx, exp_q[0].idx);
                chk("max", max, exp_q[0].maxv);
                chk("in_ready_done", in_ready, 0);
`ifdef MAXNET_ITER_OUT_EN
                chk("out_iters", out_iters, exp_q[0].iters);
`endif
                if (first_valid) chk("latency", cyc - exp_q[0].acc + 1, exp_q[0].iters + 2);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    first_valid = 1'b1;
                end else begin
                    first_valid = 1'b0;
                end
            end
        end
    end

    function automatic logic [N*W-1:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) fail_now("in_ready_wait");
    endtask

    // Issue one request; hold out_ready low for 'hold' cycles of DONE
    task automatic run_txn(input logic [N*W-1:0] d, input logic [31:0] e, input int hold,
                           input bit busy_valid);
        exp_t x;
        int   t;
        wait_ready();
        in_data  = d;
        epsilon  = e;
        in_valid = 1'b1;
        x        = model(d, e);
        @(posedge clk);
        #1;
        x.acc = cyc;
        exp_q.push_back(x);
        in_valid = busy_valid;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        epsilon  = $urandom_range(0, 32'h5555);
        t = 0;
        while (!out_valid && t < 300) begin
            chk("in_ready_iter", in_ready, 0);
            @(posedge clk);
            #1;
            t++;
        end
        if (!out_valid) begin
            fail_now("out_valid_wait");
        end else begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("out_valid_after_hs", out_valid, 0);
            chk("in_ready_after_hs", in_ready, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] t1;
        logic [N*W-1:0] d;
        t1 = pack4(32'h10000, 32'h8000, 32'h4000, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_found", found, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_win_idx", win_idx, 0);
        chk("rst_max", max, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Directed cases
        run_txn(t1, 32'h3333, 0, 1'b0);
        run_txn(pack4(32'h0, 32'h0, 32'h20000, 32'h0), 32'h3333, 0, 1'b0);
        run_txn(pack4(32'h8000, 32'h8000, 32'h0, 32'h0), 32'h4000, 0, 1'b0);
        run_txn(pack4(32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000), 32'h3333, 0, 1'b0);
        // Back-pressure with in_valid held high while busy
        run_txn(t1, 32'h3333, 10, 1'b1);

        // Reset during the second update of the first case
        wait_ready();
        in_data  = t1;
        epsilon  = 32'h3333;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_found", found, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_win_idx", win_idx, 0);
        chk("midrst_max", max, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready_rel", in_ready, 1);
        chk("midrst_no_out", out_valid, 0);
        run_txn(t1, 32'h3333, 0, 1'b0);

        // Randomised scores and weights
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N; i++) begin
                d[i*W +: W] = 32'($urandom_range(0, 32'h80000)) - 32'h40000;
            end
            if (n % 6 == 5) d[W +: W] = d[0 +: W];
            run_txn(d, 32'($urandom_range(32'h100, 32'h5555)), $urandom_range(0, 3), n[0]);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
